// File: rtl/ensamblador_bytes_pkg.sv
// Shared definitions for the RX byte assembler and its TX splitter counterpart.
package ensamblador_bytes_pkg;

  typedef enum logic {
    S_RECV = 1'b0,
    S_HOLD = 1'b1
  } estado_t;

  localparam int unsigned TAM_DATA_DEF    = 32;
  localparam int unsigned TAM_BYTE_DEF    = 8;
  localparam int unsigned BYTES_X_PALABRA = TAM_DATA_DEF / TAM_BYTE_DEF;

  function automatic int unsigned bytes_x_palabra(input int unsigned tam_data,
                                                  input int unsigned tam_byte);
    return tam_data / tam_byte;
  endfunction

endpackage

// File: rtl/ensamblador_bytes_contador_timeout.sv
// Idle-cycle watchdog for a partially assembled word.
module contador_timeout #(
  parameter int unsigned TIMEOUT_CICLOS = 1000000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expired
);

  generate
    if (TIMEOUT_CICLOS == 0) begin : g_off
      logic unused_entradas;
      assign unused_entradas = ^{i_clk, i_reset, i_clear, i_run};
      assign o_expired = 1'b0;
    end else begin : g_on
      localparam int unsigned TW = $clog2(TIMEOUT_CICLOS + 1);
      localparam logic [TW-1:0] LIMITE = TW'(TIMEOUT_CICLOS - 1);

      logic [TW-1:0] timer_q, timer_d;
      logic          fin;

      // Count idle cycles while running; restart on clear, pause or expiry.
      always_comb begin
        fin     = i_run && (timer_q == LIMITE);
        timer_d = timer_q;
        if (i_clear || !i_run || fin) timer_d = '0;
        else                          timer_d = timer_q + 1'b1;
      end

      assign o_expired = fin && !i_clear;

      // Timer register.
      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) timer_q <= '0;
        else         timer_q <= timer_d;
      end
    end
  endgenerate

endmodule

// File: rtl/ensamblador_bytes.sv
// Pops bytes from the RX FIFO and assembles them MSB-first into words,
// holding each finished word under a valid/ready handshake.
module ensamblador_bytes
  import ensamblador_bytes_pkg::*;
#(
  parameter int unsigned TAM_DATA       = 32,
  parameter int unsigned TAM_BYTE       = 8,
  parameter int unsigned TIMEOUT_CICLOS = 1000000
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_clear,
  input  logic                i_fifo_empty,
  input  logic [TAM_BYTE-1:0] i_byte_data,
  output logic                o_fifo_rd,
  output logic [TAM_DATA-1:0] o_palabra,
  output logic                o_palabra_valid,
  input  logic                i_palabra_ready,
  output logic                o_timeout
);

  localparam int unsigned N  = bytes_x_palabra(TAM_DATA, TAM_BYTE);
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] ULTIMO = CW'(N - 1);

  estado_t             state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [TAM_DATA-1:0] palabra_q, palabra_d;
  logic                valid_q, valid_d;
  logic                timeout_q, timeout_d;
  logic                pop;
  logic                timer_run;
  logic                expirado;

  assign pop       = (state_q == S_RECV) && !i_fifo_empty && !i_clear;
  assign timer_run = (state_q == S_RECV) && (cnt_q != '0) && !pop;

  contador_timeout #(
    .TIMEOUT_CICLOS(TIMEOUT_CICLOS)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (i_clear),
    .i_run    (timer_run),
    .o_expired(expirado)
  );

  // Next-state: clear beats pop, handshake and timeout.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    palabra_d = palabra_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    if (i_clear) begin
      state_d = S_RECV;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_RECV: begin
          if (pop) begin
            // Shift form also covers TAM_DATA == TAM_BYTE without an empty slice.
            palabra_d = (palabra_q << TAM_BYTE) | TAM_DATA'(i_byte_data);
            if (cnt_q == ULTIMO) begin
              cnt_d   = '0;
              state_d = S_HOLD;
              valid_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else if (expirado) begin
            cnt_d     = '0;
            timeout_d = 1'b1;
          end
        end
        S_HOLD: begin
          if (i_palabra_ready) begin
            state_d = S_RECV;
            valid_d = 1'b0;
          end
        end
        default: state_d = S_RECV;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= S_RECV;
      cnt_q     <= '0;
      palabra_q <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      palabra_q <= palabra_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_fifo_rd       = pop;
  assign o_palabra       = palabra_q;
  assign o_palabra_valid = valid_q;
  assign o_timeout       = timeout_q;

endmodule

// File: tb/tb_ensamblador_bytes.sv
// Scoreboard bench for ensamblador_bytes with a first-word fall-through FIFO model.
module tb_ensamblador_bytes;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_clear = 1'b0;
  logic        i_fifo_empty = 1'b1;
  logic [7:0]  i_byte_data = '0;
  logic        o_fifo_rd;
  logic [31:0] o_palabra;
  logic        o_palabra_valid;
  logic        i_palabra_ready = 1'b1;
  logic        o_timeout;

  ensamblador_bytes #(
    .TAM_DATA      (32),
    .TAM_BYTE      (8),
    .TIMEOUT_CICLOS(16)
  ) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_clear        (i_clear),
    .i_fifo_empty   (i_fifo_empty),
    .i_byte_data    (i_byte_data),
    .o_fifo_rd      (o_fifo_rd),
    .o_palabra      (o_palabra),
    .o_palabra_valid(o_palabra_valid),
    .i_palabra_ready(i_palabra_ready),
    .o_timeout      (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  logic [7:0]  fifo[$];
  logic [31:0] exp_q[$];
  int cyc = 0;
  int rd_count = 0;
  int timeout_count = 0;
  int last_rd_cyc = 0;
  int rise_cyc = 0;
  int n_pass = 0;
  int n_total = 0;
  logic prev_valid = 1'b0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
  endtask

  // FIFO model: present head mid-cycle, sample pop strobe, pop after the edge.
  initial begin
    logic rd_now;
    forever begin
      @(negedge i_clk);
      i_fifo_empty = (fifo.size() == 0);
      i_byte_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
      #1;
      rd_now = o_fifo_rd;
      if (rd_now) begin
        rd_count++;
        last_rd_cyc = cyc;
      end
      @(posedge i_clk);
      if (rd_now && !i_reset && fifo.size() != 0) void'(fifo.pop_front());
    end
  end

  // Monitor: compare every accepted word against the scoreboard head.
  always @(negedge i_clk) begin
    if (o_timeout) timeout_count++;
    if (o_palabra_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = o_palabra_valid;
    if (o_palabra_valid && i_palabra_ready && !i_clear && !i_reset) begin
      if (exp_q.size() == 0) chk("unexpected_word", o_palabra, 32'hxxxxxxxx);
      else chk("word", o_palabra, exp_q.pop_front());
    end
  end

  task automatic push_word(input logic [31:0] w, input bit expect_it);
    for (int i = 3; i >= 0; i--) fifo.push_back(w[i*8 +: 8]);
    if (expect_it) exp_q.push_back(w);
  endtask

  task automatic wait_sb(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge i_clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk({name, "_timeout_wait"}, exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (2) @(posedge i_clk);
  endtask

  task automatic wait_fifo(input int budget);
    int n = 0;
    while (fifo.size() != 0 && n < budget) begin
      @(posedge i_clk);
      n++;
    end
    if (fifo.size() != 0) chk("fifo_drain", fifo.size(), 0);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge i_clk);
      #2;
      n++;
    end while (!o_palabra_valid && n < budget);
    chk({name, "_valid"}, o_palabra_valid, 1'b1);
  endtask

  initial begin
    int rd0, to0;
    // Reset state
    #2;
    chk("rst_palabra", o_palabra, 32'h0);
    chk("rst_valid", o_palabra_valid, 1'b0);
    chk("rst_timeout", o_timeout, 1'b0);
    chk("rst_rd", o_fifo_rd, 1'b0);
    repeat (2) @(posedge i_clk);
    #2 i_reset = 1'b0;

    // 1: back-to-back bytes
    rd0 = rd_count; to0 = timeout_count;
    push_word(32'hDEADBEEF, 1'b1);
    wait_sb("t1", 40);
    chk("t1_rd_pulses", rd_count - rd0, 4);
    chk("t1_latency", rise_cyc - last_rd_cyc, 1);

    // 2: five empty cycles between bytes, below timeout
    to0 = timeout_count;
    exp_q.push_back(32'hDEADBEEF);
    begin
      logic [31:0] w;
      w = 32'hDEADBEEF;
      for (int i = 3; i >= 0; i--) begin
        fifo.push_back(w[i*8 +: 8]);
        wait_fifo(20);
        repeat (5) @(posedge i_clk);
      end
    end
    wait_sb("t2", 40);
    chk("t2_no_timeout", timeout_count - to0, 0);

    // 3: consumer stalls, FIFO already holds the next word
    @(posedge i_clk); #2 i_palabra_ready = 1'b0;
    push_word(32'h10203040, 1'b1);
    push_word(32'h01020304, 1'b1);
    wait_valid("t3", 40);
    rd0 = rd_count;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk); #2;
      chk("t3_hold_word", o_palabra, 32'h10203040);
      chk("t3_hold_rd", o_fifo_rd, 1'b0);
    end
    chk("t3_no_pops", rd_count - rd0, 0);
    chk("t3_fifo_kept", fifo.size(), 4);
    @(posedge i_clk); #2 i_palabra_ready = 1'b1;
    wait_sb("t3", 60);

    // 4: partial word starves into a timeout
    to0 = timeout_count;
    fifo.push_back(8'h11);
    fifo.push_back(8'h22);
    wait_fifo(20);
    repeat (24) @(posedge i_clk);
    chk("t4_one_timeout", timeout_count - to0, 1);
    push_word(32'hAABBCCDD, 1'b1);
    wait_sb("t4", 40);
    chk("t4_single_pulse", timeout_count - to0, 1);

    // 5: clear after 3 bytes, then a fresh word
    to0 = timeout_count;
    fifo.push_back(8'h01);
    fifo.push_back(8'h02);
    fifo.push_back(8'h03);
    wait_fifo(20);
    @(posedge i_clk); #2 i_clear = 1'b1;
    @(posedge i_clk); #2 i_clear = 1'b0;
    push_word(32'h55667788, 1'b1);
    wait_sb("t5", 40);
    chk("t5_no_timeout", timeout_count - to0, 0);
    // clear while holding a word
    @(posedge i_clk); #2 i_palabra_ready = 1'b0;
    push_word(32'h9ABCDEF0, 1'b0);
    wait_valid("t5h", 40);
    @(posedge i_clk); #2 i_clear = 1'b1;
    @(posedge i_clk); #2 i_clear = 1'b0;
    @(negedge i_clk); #2;
    chk("t5_clear_drops_valid", o_palabra_valid, 1'b0);
    i_palabra_ready = 1'b1;
    repeat (3) @(posedge i_clk);

    // 6: asynchronous reset mid-word
    fifo.push_back(8'hDE);
    fifo.push_back(8'hAD);
    wait_fifo(20);
    @(posedge i_clk); #3 i_reset = 1'b1;
    #1;
    chk("t6_rst_palabra", o_palabra, 32'h0);
    chk("t6_rst_valid", o_palabra_valid, 1'b0);
    chk("t6_rst_timeout", o_timeout, 1'b0);
    fifo.delete();
    repeat (2) @(posedge i_clk);
    #3 i_reset = 1'b0;
    push_word(32'h12345678, 1'b1);
    wait_sb("t6", 40);

    chk("end_scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
